rle_ram_arbiter: RTL and testbench

- Shares the single-port 64K x 8 pixel RAM between two clients.
- Read client: the pixel-fetch sequencer, which reads the R/G/B planes at base addresses 0/16384/32768.
- Write client: the RLE decoder, which fills the planes with decoded bytes.
- The block owns the RAM address, write-data and write-enable pins, arbitrates round-robin or read-priority, and returns read data with a one-cycle strobe.

---
 rtl/rle_ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rle_ram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_ram_arbiter.sv
// -----------------------------------------------------------------------------
// rle_ram_arbiter
//
// Shares one single-port pixel RAM (asynchronous read, synchronous write)
// between two clients:
//   - the pixel-fetch sequencer (read client), which walks the R/G/B planes
//   - the RLE decoder (write client), which fills the planes with decoded bytes
//
// Every access takes two clock cycles. The granting edge drives the RAM
// address (and write data/enable for a write). The following edge either
// captures the RAM read data or commits the write. Contention is resolved
// round-robin, or with reads always winning when RD_PRIO is nonzero.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   rd_req    read request, held with rd_addr stable until rd_valid
//   rd_addr   read address
//   rd_data   registered read data, holds its value between reads
//   rd_valid  one-cycle strobe: rd_data belongs to the current read
//   wr_req    write request, held with wr_addr/wr_data stable until wr_ack
//   wr_addr   write address
//   wr_data   write data
//   wr_ack    one-cycle strobe: the write has been committed to the RAM
//   a         RAM address (registered)
//   d         RAM write data (registered)
//   we        RAM write enable (registered)
//   spo       RAM asynchronous read data for address a
//   busy      high while an access is in flight
// -----------------------------------------------------------------------------
module rle_ram_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RD_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] a,
   output logic [DATA_W-1:0] d,
   output logic              we,
   input  logic [DATA_W-1:0] spo,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RD_CAP    = 2'd1,
      WR_COMMIT = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_t;

   state_t            state;
   state_t            state_next;
   grant_t            last_grant;
   grant_t            last_grant_next;
   logic [ADDR_W-1:0] a_next;
   logic [DATA_W-1:0] d_next;
   logic              we_next;
   logic [DATA_W-1:0] rd_data_next;
   logic              rd_valid_next;
   logic              wr_ack_next;
   logic              pick_read;

   // Arbitration choice, only meaningful in IDLE. With a lone request that
   // client wins; under contention reads win outright in priority mode,
   // otherwise the client that was not served last goes next.
   always_comb begin
      pick_read = 1'b0;
      if (rd_req && wr_req) begin
         if (RD_PRIO != 0) begin
            pick_read = 1'b1;
         end else begin
            pick_read = (last_grant == GRANT_WRITE);
         end
      end else begin
         pick_read = rd_req;
      end
   end

   // Next-state and next-output logic. Strobes and write enable default low
   // so each is high for exactly one cycle; address and data default to
   // holding so a stays stable through the whole access.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      a_next          = a;
      d_next          = d;
      we_next         = 1'b0;
      rd_data_next    = rd_data;
      rd_valid_next   = 1'b0;
      wr_ack_next     = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req && pick_read) begin
               a_next          = rd_addr;
               last_grant_next = GRANT_READ;
               state_next      = RD_CAP;
            end else if (wr_req) begin
               a_next          = wr_addr;
               d_next          = wr_data;
               we_next         = 1'b1;
               last_grant_next = GRANT_WRITE;
               state_next      = WR_COMMIT;
            end
         end
         RD_CAP: begin
            // a has been stable for a full cycle, so spo is settled here.
            rd_data_next  = spo;
            rd_valid_next = 1'b1;
            state_next    = IDLE;
         end
         WR_COMMIT: begin
            // The RAM samples we=1 on this edge; the write is done after it.
            wr_ack_next = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers. Reset clears everything at once, which
   // drops we mid-write and suppresses any strobe for the aborted access.
   // last_grant resets to write so the first contention serves the read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= GRANT_WRITE;
         a          <= '0;
         d          <= '0;
         we         <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         wr_ack     <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         a          <= a_next;
         d          <= d_next;
         we         <= we_next;
         rd_data    <= rd_data_next;
         rd_valid   <= rd_valid_next;
         wr_ack     <= wr_ack_next;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_rle_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rle_ram_arbiter
//
// Drives two arbiter instances from the same client requests: dut0 uses
// round-robin arbitration, dut1 uses read priority. Each instance has its
// own RAM model with an asynchronous read port and a registered write port.
// -----------------------------------------------------------------------------
module tb_rle_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          wr_ack0, wr_ack1;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1;
   logic          we0, we1;
   logic [DW-1:0] spo0, spo1;
   logic          busy0, busy1;

   logic [DW-1:0] mem0 [0:65535];
   logic [DW-1:0] mem1 [0:65535];
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   int checks;
   int failures;

   rle_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_PRIO(0)) dut0 (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack0),
      .a(a0), .d(d0), .we(we0), .spo(spo0), .busy(busy0)
   );

   rle_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_PRIO(1)) dut1 (
      .clk(clk), .rst(rst),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack1),
      .a(a1), .d(d1), .we(we1), .spo(spo1), .busy(busy1)
   );

   // RAM models: asynchronous read, write on the rising edge with we high.
   // A backdoor port preloads contents while the arbiters are idle.
   assign spo0 = mem0[a0];
   assign spo1 = mem1[a1];

   always @(posedge clk) begin
      if (we0) mem0[a0] <= d0;
      else if (bd_we) mem0[bd_addr] <= bd_data;
   end

   always @(posedge clk) begin
      if (we1) mem1[a1] <= d1;
      else if (bd_we) mem1[bd_addr] <= bd_data;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #4;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      int bad;
      rst = 1'b0;
      #12;
      checks++;
      if ({a0, d0, we0, rd_data0, rd_valid0, wr_ack0, busy0} !== '0) begin
         failures++;
         $display("FAIL reset_dut0 got a=%h d=%h we=%b rd_data=%h rv=%b ack=%b busy=%b expected all zero",
                  a0, d0, we0, rd_data0, rd_valid0, wr_ack0, busy0);
      end
      checks++;
      if ({a1, d1, we1, rd_data1, rd_valid1, wr_ack1, busy1} !== '0) begin
         failures++;
         $display("FAIL reset_dut1 got a=%h we=%b busy=%b expected all zero", a1, we1, busy1);
      end
      #10;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (a0 !== 16'h0 || we0 !== 1'b0 || busy0 !== 1'b0 || rd_valid0 !== 1'b0 || wr_ack0 !== 1'b0 ||
             a1 !== 16'h0 || we1 !== 1'b0 || busy1 !== 1'b0 || rd_valid1 !== 1'b0 || wr_ack1 !== 1'b0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL idle_after_reset got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_single_read;
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 16'h4001; bd_data = 8'h5A;
      @(negedge clk);
      bd_we = 1'b0;
      tick();
      rd_req = 1'b1; rd_addr = 16'h4001;
      tick();
      checks++;
      if (a0 !== 16'h4001 || busy0 !== 1'b1 || rd_valid0 !== 1'b0 || we0 !== 1'b0) begin
         failures++;
         $display("FAIL read_grant got a=%h busy=%b rv=%b we=%b expected a=4001 busy=1 rv=0 we=0",
                  a0, busy0, rd_valid0, we0);
      end
      tick();
      checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 8'h5A || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL read_data got rv=%b data=%h busy=%b expected rv=1 data=5a busy=0",
                  rd_valid0, rd_data0, busy0);
      end
      rd_req = 1'b0;
      tick();
      checks++;
      if (rd_valid0 !== 1'b0 || rd_data0 !== 8'h5A || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL read_strobe_end got rv=%b data=%h busy=%b expected rv=0 data=5a busy=0",
                  rd_valid0, rd_data0, busy0);
      end
   endtask

   task automatic test_write_readback;
      wr_req = 1'b1; wr_addr = 16'h8002; wr_data = 8'hC3;
      tick();
      checks++;
      if (we0 !== 1'b1 || a0 !== 16'h8002 || d0 !== 8'hC3 || wr_ack0 !== 1'b0) begin
         failures++;
         $display("FAIL write_grant got we=%b a=%h d=%h ack=%b expected we=1 a=8002 d=c3 ack=0",
                  we0, a0, d0, wr_ack0);
      end
      tick();
      checks++;
      if (we0 !== 1'b0 || wr_ack0 !== 1'b1 || mem0[16'h8002] !== 8'hC3) begin
         failures++;
         $display("FAIL write_commit got we=%b ack=%b ram=%h expected we=0 ack=1 ram=c3",
                  we0, wr_ack0, mem0[16'h8002]);
      end
      wr_req = 1'b0;
      rd_req = 1'b1; rd_addr = 16'h8002;
      tick();
      checks++;
      if (wr_ack0 !== 1'b0 || we0 !== 1'b0 || a0 !== 16'h8002) begin
         failures++;
         $display("FAIL write_ack_end got ack=%b we=%b a=%h expected ack=0 we=0 a=8002",
                  wr_ack0, we0, a0);
      end
      tick();
      checks++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== 8'hC3) begin
         failures++;
         $display("FAIL readback got rv=%b data=%h expected rv=1 data=c3", rd_valid0, rd_data0);
      end
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_contention;
      logic exp_rd;
      int   rv0, wa0, rv1, wa1, bad0, bad1;
      pulse_reset();
      rv0 = 0; wa0 = 0; rv1 = 0; wa1 = 0; bad0 = 0; bad1 = 0;
      rd_req = 1'b1; rd_addr = 16'h0010;
      wr_req = 1'b1; wr_addr = 16'h4020; wr_data = 8'h9E;
      for (int k = 0; k < 8; k++) begin
         exp_rd = ((k % 2) == 0);
         tick();
         if (we0 !== ~exp_rd || a0 !== (exp_rd ? 16'h0010 : 16'h4020) || busy0 !== 1'b1) bad0++;
         if (we1 !== 1'b0 || a1 !== 16'h0010 || busy1 !== 1'b1) bad1++;
         tick();
         if (rd_valid0 !== exp_rd || wr_ack0 !== ~exp_rd) bad0++;
         if (rd_valid1 !== 1'b1 || wr_ack1 !== 1'b0) bad1++;
         rv0 += int'(rd_valid0); wa0 += int'(wr_ack0);
         rv1 += int'(rd_valid1); wa1 += int'(wr_ack1);
      end
      checks++;
      if (bad0 !== 0) begin
         failures++;
         $display("FAIL rr_order got %0d off-sequence samples expected 0", bad0);
      end
      checks++;
      if (rv0 !== 4 || wa0 !== 4) begin
         failures++;
         $display("FAIL rr_counts got rv=%0d ack=%0d expected 4 and 4", rv0, wa0);
      end
      checks++;
      if (bad1 !== 0 || rv1 !== 8 || wa1 !== 0) begin
         failures++;
         $display("FAIL prio_reads got bad=%0d rv=%0d ack=%0d expected 0 8 0", bad1, rv1, wa1);
      end
      rd_req = 1'b0;
      tick();
      checks++;
      if (we1 !== 1'b1 || a1 !== 16'h4020 || d1 !== 8'h9E) begin
         failures++;
         $display("FAIL prio_write_grant got we=%b a=%h d=%h expected we=1 a=4020 d=9e", we1, a1, d1);
      end
      tick();
      checks++;
      if (wr_ack1 !== 1'b1 || mem1[16'h4020] !== 8'h9E) begin
         failures++;
         $display("FAIL prio_write_ack got ack=%b ram=%h expected ack=1 ram=9e", wr_ack1, mem1[16'h4020]);
      end
      wr_req = 1'b0;
      tick();
      checks++;
      if (wr_ack1 !== 1'b0 || busy1 !== 1'b0 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL drain got ack1=%b busy1=%b busy0=%b expected 0 0 0", wr_ack1, busy1, busy0);
      end
   endtask

   task automatic test_reset_mid_write;
      int spurious;
      wr_req = 1'b1; wr_addr = 16'h1234; wr_data = 8'h77;
      tick();
      checks++;
      if (we0 !== 1'b1 || we1 !== 1'b1 || a0 !== 16'h1234) begin
         failures++;
         $display("FAIL abort_grant got we0=%b we1=%b a=%h expected 1 1 1234", we0, we1, a0);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (we0 !== 1'b0 || busy0 !== 1'b0 || a0 !== 16'h0 || we1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL abort_clear got we0=%b busy0=%b a0=%h we1=%b busy1=%b expected all zero",
                  we0, busy0, a0, we1, busy1);
      end
      spurious = 0;
      tick();
      if (wr_ack0 !== 1'b0 || wr_ack1 !== 1'b0 || we0 !== 1'b0) spurious++;
      #1;
      rst = 1'b1;
      tick();
      checks++;
      if (spurious !== 0 || wr_ack0 !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_ack got %0d strobes expected 0", spurious + int'(wr_ack0));
      end
      checks++;
      if (we0 !== 1'b1 || a0 !== 16'h1234 || d0 !== 8'h77) begin
         failures++;
         $display("FAIL reserve_grant got we=%b a=%h d=%h expected we=1 a=1234 d=77", we0, a0, d0);
      end
      tick();
      checks++;
      if (wr_ack0 !== 1'b1 || mem0[16'h1234] !== 8'h77 || wr_ack1 !== 1'b1) begin
         failures++;
         $display("FAIL reserve_commit got ack0=%b ack1=%b ram=%h expected 1 1 77",
                  wr_ack0, wr_ack1, mem0[16'h1234]);
      end
      wr_req = 1'b0;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      rd_req   = 1'b0;
      rd_addr  = '0;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      bd_we    = 1'b0;
      bd_addr  = '0;
      bd_data  = '0;
      test_reset();
      test_single_read();
      test_write_readback();
      test_contention();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
